// File: rtl/bmm_pkg.sv
// rtl/bmm_pkg.sv - shared constants, width helpers and stage record for the Barrett multiplier pipe
// Optional feature macro: BMM_TAG_EN (adds a tag field to the stage record)
package bmm_pkg;

  localparam int BMM_LAT       = 4;
  localparam int BMM_TAG_W_MAX = 32;

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  function automatic int q_w(input int n);
    return n + 1;
  endfunction

  function automatic int res_w(input int n);
    return n + 2;
  endfunction

  // Per-stage control record; the tag rides alongside the valid bit
  typedef struct packed {
    logic valid;
`ifdef BMM_TAG_EN
    logic [BMM_TAG_W_MAX-1:0] tag;
`endif
  } stage_ctl_t;

endpackage

// File: rtl/bmm_barrett_reduce_core.sv
// rtl/bmm_barrett_reduce_core.sv - combinational residue (stage 3) and final correction (stage 4) arithmetic
// Optional feature macro: BMM_TAG_EN (not used here)
module bmm_barrett_reduce_core
  import bmm_pkg::*;
#(
  parameter int N = 32
)(
  input  logic [N+1:0] t_lo,
  input  logic [N:0]   q,
  input  logic [N-1:0] m,
  input  logic [N+1:0] r_in,
  output logic [N+1:0] r,
  output logic [N-1:0] z
);

  localparam int RW = res_w(N);

  logic [RW-1:0] qm;
  logic [RW-1:0] m1;
  logic [RW-1:0] m2;
  logic [RW-1:0] sub1;
  logic [RW-1:0] sub2;
  logic [RW-1:0] sel;
  logic          unused_sel_hi;

  // Residue T - q*M; only N+2 bits are kept because the true residue is below 3M
  always_comb begin
    qm = {1'b0, q} * {2'b00, m};
    r  = t_lo - qm;
  end

  // Bring the residue from [0, 3M) into [0, M) with two conditional subtracts
  always_comb begin
    m1   = {2'b00, m};
    m2   = {1'b0, m, 1'b0};
    sub1 = r_in - m1;
    sub2 = r_in - m2;
    if (r_in >= m2) begin
      sel = sub2;
    end else if (r_in >= m1) begin
      sel = sub1;
    end else begin
      sel = r_in;
    end
  end

  assign z             = sel[N-1:0];
  assign unused_sel_hi = ^sel[RW-1:N];

endmodule

// File: rtl/bmm_barrett_pipe.sv
// rtl/bmm_barrett_pipe.sv - four-stage pipelined Barrett modular multiplier with loadable modulus
// Optional feature macro: BMM_TAG_EN (adds in_tag/out_tag carried alongside each operand pair)
module bmm_barrett_pipe
  import bmm_pkg::*;
#(
  parameter int N     = 32,
  parameter int LAT   = 4,
  parameter int TAG_W = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N-1:0]     cfg_m,
  input  logic [N:0]       cfg_mu,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BMM_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic [N-1:0]     out_z
);

  localparam int PW = prod_w(N);
  localparam int QW = q_w(N);
  localparam int RW = res_w(N);

  if (LAT != BMM_LAT) begin : g_lat_check
    $error("bmm_barrett_pipe: LAT must be 4");
  end

  if (TAG_W < 1 || TAG_W > BMM_TAG_W_MAX) begin : g_tag_check
    $error("bmm_barrett_pipe: TAG_W out of range");
  end

  logic [N-1:0]     m_r;
  logic [N:0]       mu_r;
  logic             cfg_loaded;

  stage_ctl_t       s1_ctl;
  stage_ctl_t       s2_ctl;
  stage_ctl_t       s3_ctl;
  logic [PW-1:0]    s1_t;
  logic [RW-1:0]    s2_t;
  logic [QW-1:0]    s2_q;
  logic [RW-1:0]    s3_r;

  logic             stall;
  logic             cfg_fire;
  logic             in_fire;
  logic [PW-1:0]    t_next;
  logic [N:0]       t_shift;
  logic [2*N+1:0]   q_prod;
  logic [RW-1:0]    r_next;
  logic [N-1:0]     z_next;
  logic             unused_q_lo;

  assign stall     = out_valid & ~out_ready;
  assign cfg_ready = ~(s1_ctl.valid | s2_ctl.valid | s3_ctl.valid | out_valid);
  assign cfg_fire  = cfg_valid & cfg_ready;
  // A config load takes the cycle; the operand waits for the new modulus
  assign in_ready  = ~stall & cfg_loaded & ~cfg_fire;
  assign in_fire   = in_valid & in_ready;

  // Stage-1 product and stage-2 quotient estimate
  assign t_next      = {{N{1'b0}}, in_a} * {{N{1'b0}}, in_b};
  assign t_shift     = s1_t[PW-1:N-1];
  assign q_prod      = {{(N+1){1'b0}}, t_shift} * {{(N+1){1'b0}}, mu_r};
  assign unused_q_lo = ^q_prod[N:0];

  bmm_barrett_reduce_core #(
    .N (N)
  ) u_core (
    .t_lo (s2_t),
    .q    (s2_q),
    .m    (m_r),
    .r_in (s3_r),
    .r    (r_next),
    .z    (z_next)
  );

  // Modulus and Barrett constant, loaded only while the pipeline is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r        <= '0;
      mu_r       <= '0;
      cfg_loaded <= 1'b0;
    end else if (cfg_fire) begin
      m_r        <= cfg_m;
      mu_r       <= cfg_mu;
      cfg_loaded <= 1'b1;
    end
  end

  // Stages 1-3 advance together and freeze while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctl <= '0;
      s2_ctl <= '0;
      s3_ctl <= '0;
      s1_t   <= '0;
      s2_t   <= '0;
      s2_q   <= '0;
      s3_r   <= '0;
    end else if (!stall) begin
      s1_ctl.valid <= in_fire;
`ifdef BMM_TAG_EN
      s1_ctl.tag   <= BMM_TAG_W_MAX'(in_tag);
`endif
      s1_t         <= t_next;
      s2_ctl       <= s1_ctl;
      s2_t         <= s1_t[RW-1:0];
      s2_q         <= q_prod[2*N+1:N+1];
      s3_ctl       <= s2_ctl;
      s3_r         <= r_next;
    end
  end

  // Stage 4: result registers change only when a valid entry arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
`ifdef BMM_TAG_EN
      out_tag   <= '0;
`endif
    end else if (!stall) begin
      out_valid <= s3_ctl.valid;
      if (s3_ctl.valid) begin
        out_z   <= z_next;
`ifdef BMM_TAG_EN
        out_tag <= s3_ctl.tag[TAG_W-1:0];
`endif
      end
    end
  end

`ifdef BMM_TAG_EN
  if (TAG_W < BMM_TAG_W_MAX) begin : g_tag_hi
    logic unused_tag_hi;
    assign unused_tag_hi = ^s3_ctl.tag[BMM_TAG_W_MAX-1:TAG_W];
  end
`endif

endmodule

// File: tb/tb_bmm_barrett_pipe.sv
// tb/tb_bmm_barrett_pipe.sv - scoreboard bench for the Barrett multiplier pipe (8-bit and 32-bit instances)
// Optional feature macro: BMM_TAG_EN (tag ports connected and checked when defined)
`timescale 1ns/1ps
module tb_bmm_barrett_pipe;

  localparam int TW = 8;
  localparam logic [31:0] M32  = 32'hFFFF_FFFB;
  localparam logic [32:0] MU32 = 33'h1_0000_0005;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        cfg_valid8, cfg_ready8;
  logic [7:0]  cfg_m8;
  logic [8:0]  cfg_mu8;
  logic        in_valid8, in_ready8;
  logic [7:0]  a8, b8;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  z8;

  logic        cfg_valid32, cfg_ready32;
  logic [31:0] cfg_m32;
  logic [32:0] cfg_mu32;
  logic        in_valid32, in_ready32;
  logic [31:0] a32, b32;
  logic        out_valid32;
  logic        out_ready32;
  logic [31:0] z32;
`ifdef BMM_TAG_EN
  logic [TW-1:0] tag8, otag8, tag32, otag32;
`endif

  bmm_barrett_pipe #(.N(8), .LAT(4), .TAG_W(TW)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid8), .cfg_ready(cfg_ready8), .cfg_m(cfg_m8), .cfg_mu(cfg_mu8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_a(a8), .in_b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
`ifdef BMM_TAG_EN
    .in_tag(tag8), .out_tag(otag8),
`endif
    .out_z(z8)
  );

  bmm_barrett_pipe #(.N(32), .LAT(4), .TAG_W(TW)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid32), .cfg_ready(cfg_ready32), .cfg_m(cfg_m32), .cfg_mu(cfg_mu32),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_a(a32), .in_b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32),
`ifdef BMM_TAG_EN
    .in_tag(tag32), .out_tag(otag32),
`endif
    .out_z(z32)
  );

  typedef struct {
    logic [31:0]   z;
    logic [TW-1:0] tag;
    int            acc;
    bit            chk_lat;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   m8_cur = 251;
  bit   bp_en = 1'b0;
  int   bp_i = 0;
  bit   hold8 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] mod8(input logic [7:0] a, input logic [7:0] b);
    return 8'((int'(a) * int'(b)) % m8_cur);
  endfunction

  function automatic logic [31:0] mod32(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = 64'(a) * 64'(b);
    return 32'(p % 64'(M32));
  endfunction

  // Backpressure pattern 1-0-0-1 on the 8-bit consumer when enabled
  always begin
    @(negedge clk);
    if (bp_en) begin
      out_ready8 = ((bp_i % 4) == 0) || ((bp_i % 4) == 3);
      bp_i++;
    end else begin
      out_ready8 = 1'b1;
    end
  end

  // Monitor for the 8-bit instance
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid8) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_out8: got out_z=%0d with no result outstanding, expected none", z8);
      end else begin
        if (!hold8 && q8[0].chk_lat) check("latency8", cyc - q8[0].acc, 4);
        check("out_z8", z8, q8[0].z);
`ifdef BMM_TAG_EN
        check("out_tag8", otag8, q8[0].tag);
`endif
        if (out_ready8) begin
          void'(q8.pop_front());
          hold8 = 1'b0;
        end else begin
          hold8 = 1'b1;
        end
      end
    end else begin
      hold8 = 1'b0;
    end
  end

  // Monitor for the 32-bit instance
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid32 && out_ready32) begin
      if (q32.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_out32: got out_z=%0h with no result outstanding, expected none", z32);
      end else begin
        check("out_z32", z32, q32[0].z);
`ifdef BMM_TAG_EN
        check("out_tag32", otag32, q32[0].tag);
`endif
        void'(q32.pop_front());
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e, input bit lat);
    int   waitc;
    exp_t x;
    waitc = 0;
    a8 = a;
    b8 = b;
`ifdef BMM_TAG_EN
    tag8 = a ^ b;
`endif
    in_valid8 = 1'b1;
    forever begin
      #1;
      if (in_ready8) begin
        x.z = 32'(e);
        x.tag = TW'(a ^ b);
        x.acc = cyc;
        x.chk_lat = lat;
        q8.push_back(x);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waitc++;
      if (waitc > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL send8_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", waitc);
        break;
      end
    end
    in_valid8 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input int tg);
    int   waitc;
    exp_t x;
    waitc = 0;
    a32 = a;
    b32 = b;
`ifdef BMM_TAG_EN
    tag32 = TW'(tg);
`endif
    in_valid32 = 1'b1;
    forever begin
      #1;
      if (in_ready32) begin
        x.z = e;
        x.tag = TW'(tg);
        x.acc = cyc;
        x.chk_lat = 1'b0;
        q32.push_back(x);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waitc++;
      if (waitc > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL send32_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", waitc);
        break;
      end
    end
    in_valid32 = 1'b0;
  endtask

  task automatic load_cfg8(input logic [7:0] m, input logic [8:0] mu);
    int waitc;
    waitc = 0;
    cfg_m8 = m;
    cfg_mu8 = mu;
    cfg_valid8 = 1'b1;
    forever begin
      #1;
      if (cfg_ready8) begin
        check("in_ready_during_cfg8", in_ready8, 0);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waitc++;
      if (waitc > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL cfg8_timeout: cfg_ready stayed 0 for %0d cycles, expected 1", waitc);
        break;
      end
    end
    cfg_valid8 = 1'b0;
    m8_cur = int'(m);
  endtask

  task automatic drain(input bit wide);
    int n;
    n = 0;
    while ((wide ? q32.size() : q8.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if ((wide ? q32.size() : q8.size()) != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain%0d: %0d results outstanding, expected 0", wide ? 32 : 8,
               wide ? q32.size() : q8.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic [31:0] wa, wb;
    rst_n = 1'b0;
    cfg_valid8 = 1'b0; cfg_m8 = '0; cfg_mu8 = '0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;
    cfg_valid32 = 1'b0; cfg_m32 = '0; cfg_mu32 = '0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b1;
`ifdef BMM_TAG_EN
    tag8 = '0; tag32 = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid8, 0);
    check("rst_out_z", z8, 0);
    check("rst_cfg_ready", cfg_ready8, 1);
    check("rst_in_ready", in_ready8, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_before_cfg", in_ready8, 0);

    load_cfg8(8'd251, 9'd261);
    send8(8'd250, 8'd250, 8'd1, 1'b1);
    send8(8'd200, 8'd3, 8'd98, 1'b1);
    send8(8'd0, 8'd123, 8'd0, 1'b1);
    drain(1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 250));
      rb = 8'($urandom_range(0, 250));
      send8(ra, rb, mod8(ra, rb), 1'b1);
    end
    drain(1'b0);

    bp_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 250));
      rb = 8'($urandom_range(0, 250));
      send8(ra, rb, mod8(ra, rb), 1'b0);
    end
    drain(1'b0);
    bp_en = 1'b0;
    @(negedge clk);

    send8(8'd250, 8'd2, 8'd249, 1'b1);
    send8(8'd17, 8'd15, 8'd4, 1'b1);
    send8(8'd128, 8'd128, 8'd69, 1'b1);
    cfg_valid8 = 1'b1;
    #1;
    check("cfg_ready_busy", cfg_ready8, 0);
    load_cfg8(8'd239, 9'd274);
    send8(8'd238, 8'd238, 8'd1, 1'b1);
    send8(8'd100, 8'd100, 8'd201, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 238));
      rb = 8'($urandom_range(0, 238));
      send8(ra, rb, mod8(ra, rb), 1'b1);
    end
    drain(1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 238));
      rb = 8'($urandom_range(0, 238));
      send8(ra, rb, mod8(ra, rb), 1'b0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid8, 0);
    check("async_rst_out_z", z8, 0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("in_ready_after_rst", in_ready8, 0);
    check("cfg_ready_after_rst", cfg_ready8, 1);
    @(negedge clk);

    cfg_m8 = 8'd251;
    cfg_mu8 = 9'd261;
    cfg_valid8 = 1'b1;
    a8 = 8'd250;
    b8 = 8'd250;
    in_valid8 = 1'b1;
    #1;
    check("cfg_wins_in_ready", in_ready8, 0);
    check("cfg_wins_cfg_ready", cfg_ready8, 1);
    @(negedge clk);
    cfg_valid8 = 1'b0;
    m8_cur = 251;
    #1;
    check("operand_after_cfg", in_ready8, 1);
    send8(8'd250, 8'd250, 8'd1, 1'b1);
    drain(1'b0);

    cfg_m32 = M32;
    cfg_mu32 = MU32;
    cfg_valid32 = 1'b1;
    #1;
    check("cfg_ready32", cfg_ready32, 1);
    @(negedge clk);
    cfg_valid32 = 1'b0;
    send32(32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'd1, 0);
    send32(32'd2, 32'd3, 32'd6, 1);
    send32(32'h8000_0000, 32'd2, 32'd5, 2);
    for (int i = 3; i < 16; i++) begin
      wa = $urandom_range(0, 32'hFFFF_FFFA);
      wb = $urandom_range(0, 32'hFFFF_FFFA);
      send32(wa, wb, mod32(wa, wb), i);
    end
    drain(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
